// File: rtl/pwm32_seq_pkg.sv
// rtl/pwm32_seq_pkg.sv - shared types and constants for the PWM sequencer
package pwm32_seq_pkg;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int RPT_W  = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // One sequence step: timer period, PWM compare value, extra repeats.
    typedef struct packed {
        logic [DATA_W-1:0] period;
        logic [DATA_W-1:0] cmp;
        logic [RPT_W-1:0]  rpt;
    } entry_t;

endpackage

// File: rtl/pwm32_seq_tbl.sv
// rtl/pwm32_seq_tbl.sv - 8-entry sequence table, one write port, async read
module pwm32_seq_tbl
    import pwm32_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  entry_t           wr_data_i,
    input  logic [IDX_W-1:0] rd_addr_i,
    output entry_t           rd_data_o
);

    entry_t mem_q [DEPTH];

    // Register file; a read in the same cycle as a write sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pwm32_seq.sv
// rtl/pwm32_seq.sv - table-driven PWM timer sequencer
module pwm32_seq
    import pwm32_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [3:0]        seq_len,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_period,
    input  logic [DATA_W-1:0] wr_cmp,
    input  logic [RPT_W-1:0]  wr_rpt,
    input  logic              to_flag,
    output logic              tmr_en,
    output logic              pwm_en,
    output logic [DATA_W-1:0] period,
    output logic [DATA_W-1:0] pwm_cmp,
    output logic              busy,
    output logic [IDX_W-1:0]  idx,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              stop_q, stop_d;
    logic              err_q, err_d;
    logic              tf_q;

    entry_t            wr_entry;
    entry_t            rd_entry;
    logic [IDX_W-1:0]  rd_addr;
    logic [IDX_W-1:0]  nxt_idx;
    logic              boundary;
    logic              last_entry;
    logic              len_ok;
    logic              stop_pend;

    assign wr_entry = '{period: wr_period, cmp: wr_cmp, rpt: wr_rpt};

    pwm32_seq_tbl u_tbl (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_entry)
    );

    // A period ends on the rising edge of the timer's timeout flag.
    assign boundary   = (state_q == ST_RUN) && to_flag && !tf_q;
    // ">=" keeps the sequence bounded if seq_len shrinks below idx mid-run.
    assign last_entry = (({1'b0, idx_q} + 4'd1) >= seq_len);
    assign nxt_idx    = last_entry ? '0 : idx_q + 3'd1;
    assign len_ok     = (seq_len != 4'd0) && (seq_len <= 4'(DEPTH));
    assign stop_pend  = stop_q || stop;
    // LOAD reads the current entry; in RUN the table is pre-addressed at the
    // entry that a boundary would advance to.
    assign rd_addr    = (state_q == ST_RUN) ? nxt_idx : idx_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; en low overrides everything.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && len_ok) state_d = ST_LOAD;
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    if (boundary) begin
                        if (stop_pend) begin
                            state_d = ST_DONE;
                        end else if ((rpt_q == '0) && last_entry && !loop) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        tmr_en = (state_q == ST_RUN);
        pwm_en = (state_q == ST_RUN);
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
    end

    // Datapath next values: entry loads, repeat countdown, stop latch, err.
    always_comb begin
        idx_d    = idx_q;
        period_d = period_q;
        cmp_d    = cmp_q;
        rpt_d    = rpt_q;
        stop_d   = stop_q;
        err_d    = 1'b0;
        if (!en) begin
            stop_d = 1'b0;
            idx_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stop_d = 1'b0;
                    if (start) begin
                        if (len_ok) idx_d = '0;
                        else        err_d = 1'b1;
                    end
                end
                ST_LOAD: begin
                    stop_d   = 1'b0;
                    period_d = rd_entry.period;
                    cmp_d    = rd_entry.cmp;
                    rpt_d    = rd_entry.rpt;
                end
                ST_RUN: begin
                    if (stop) stop_d = 1'b1;
                    if (boundary) begin
                        if (stop_pend) begin
                            stop_d = 1'b0;
                        end else if (rpt_q != '0) begin
                            rpt_d = rpt_q - RPT_W'(1);
                        end else if (!last_entry || loop) begin
                            idx_d    = nxt_idx;
                            period_d = rd_entry.period;
                            cmp_d    = rd_entry.cmp;
                            rpt_d    = rd_entry.rpt;
                        end
                    end
                end
                default: stop_d = 1'b0;
            endcase
        end
    end

    // Datapath registers and the timeout-flag history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            period_q <= '0;
            cmp_q    <= '0;
            rpt_q    <= '0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;
            tf_q     <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            period_q <= period_d;
            cmp_q    <= cmp_d;
            rpt_q    <= rpt_d;
            stop_q   <= stop_d;
            err_q    <= err_d;
            tf_q     <= to_flag;
        end
    end

    assign period  = period_q;
    assign pwm_cmp = cmp_q;
    assign idx     = idx_q;
    assign err     = err_q;

endmodule

// File: doc/pwm32_seq.md
PWM32_SEQ -- requirements
Module: pwm32_seq

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all logic on posedge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: en  in  1  block enable; 0 forces IDLE immediately.
REQ-004 SHALL have ports: start  in  1  single-cycle pulse, begin sequence from entry 0.
REQ-005 SHALL have ports: stop  in  1  single-cycle pulse, graceful stop at next period boundary.
REQ-006 SHALL have ports: loop  in  1  1: wrap to entry 0 after last entry; 0: finish.
REQ-007 SHALL have ports: seq_len  in  4  number of active entries; legal 1..8.
REQ-008 SHALL have ports: wr_en  in  1, wr_addr  in  3, wr_period  in  32, wr_cmp  in  32, wr_rpt  in  8  table write port.
REQ-009 SHALL have ports: to_flag  in  1  timer timeout flag from the controlled timer (up-count, periodic).
REQ-010 SHALL have ports: tmr_en  out  1, pwm_en  out  1, period  out  32, pwm_cmp  out  32  timer configuration.
REQ-011 SHALL have ports: busy  out  1, idx  out  3  current entry, done  out  1  pulse, err  out  1  pulse.

Function
REQ-012 SHALL hold an 8-entry table; each entry = {period[31:0], cmp[31:0], rpt[7:0]}; wr_en writes entry wr_addr in one cycle.
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: tmr_en=0, pwm_en=0, busy=0; start with seq_len in 1..8 -> LOAD, idx=0.
REQ-015 IDLE: start with seq_len=0 or >8 -> err=1 for one cycle, stay IDLE.
REQ-016 LOAD (1 cycle): period/pwm_cmp <= entry[idx]; rpt_cnt <= entry[idx].rpt; -> RUN; tmr_en=pwm_en=1 from the RUN cycle.
REQ-017 Boundary = rising edge of to_flag (to_flag=1 and previous-cycle to_flag=0) while in RUN.
REQ-018 On boundary with rpt_cnt!=0: rpt_cnt decrements; outputs unchanged (entry plays rpt+1 periods total).
REQ-019 On boundary with rpt_cnt==0 and idx<seq_len-1: idx increments; period, pwm_cmp, rpt_cnt load next entry in that same clock edge.
REQ-020 On boundary with rpt_cnt==0 and idx==seq_len-1: loop=1 -> idx=0 with entry 0 loaded as in REQ-019; loop=0 -> DONE.
REQ-021 stop in RUN SHALL be latched; at next boundary -> DONE regardless of rpt_cnt or loop; stop in IDLE ignored.
REQ-022 DONE (1 cycle): done=1, tmr_en=0, pwm_en=0; -> IDLE; period/pwm_cmp retain last values.
REQ-023 en=0 in any state SHALL force IDLE next cycle, clear latched stop, no done pulse.
REQ-024 start during LOAD/RUN/DONE SHALL be ignored.
REQ-025 Table writes allowed in any state; entry load in the same cycle as a write to the same address SHALL use the pre-write contents.
REQ-026 seq_len changes during RUN SHALL take effect at the next end-of-entry comparison.
REQ-027 period/pwm_cmp SHALL change only in LOAD or on a boundary, never mid-period.

Reset
REQ-028 rst_n low SHALL set: state IDLE, tmr_en 0, pwm_en 0, period 0, pwm_cmp 0, busy 0, idx 0, done 0, err 0, rpt_cnt 0, latched stop 0, to_flag history 0, all table entries 0.
REQ-029 Reset mid-RUN SHALL take effect asynchronously; no done pulse results.

Structure
REQ-030 Package pwm32_seq_pkg SHALL hold the state enumeration, DEPTH=8, IDX_W=3, RPT_W=8, and the entry struct type.
REQ-031 Table storage SHALL be a sub-module pwm32_seq_tbl (8x72 register file, one write port, one async read port).
REQ-032 busy SHALL be 1 in LOAD, RUN, DONE.

Verification
REQ-033 Entries {100,25,0},{200,150,1}, seq_len=2, loop=0, start -> period 100 for 1 boundary, 200 for 2 boundaries, then done pulse, tmr_en=0.
REQ-034 Same table, loop=1, 5 boundaries -> period sequence 100,200,200,100,200; busy stays 1.
REQ-035 Entry0 rpt=255, stop pulsed mid-period -> DONE at first following boundary, done=1 for exactly one cycle.
REQ-036 start with seq_len=0 and with seq_len=9 -> err one-cycle pulse each, tmr_en stays 0.
REQ-037 Write entry1 period=500 in the boundary cycle that loads entry1 -> old period loaded; next loop pass loads 500.
REQ-038 rst_n asserted mid-RUN, and en=0 mid-RUN -> all outputs at reset/IDLE values, no done pulse.
